// File: rtl/add64_seq_ctrl.sv
// Sequential 64-bit adder: one 16-bit slice reused over four cycles, with the carry registered between slices.
// Optional macro ADD64_SUB_EN enables subtraction (op=1 gives a-b; cout=1 means no borrow).
module add64_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic        op,
  output logic        ready,
  output logic        done,
  output logic [63:0] sum,
  output logic        cout
);

  // state  | meaning
  // S_IDLE | ready=1, waiting for start
  // S_RUN  | adding slice cnt_q, four cycles
  // S_DONE | done=1 for one cycle, sum/cout valid
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [63:0] a_q, b_q, acc_q, sum_q;
  logic        carry_q, cout_q;

  logic [15:0] a_slice, b_slice;
  logic [16:0] slice_res;

`ifndef ADD64_SUB_EN
  logic op_unused;
  assign op_unused = op;
`endif

  always_comb begin
    a_slice   = a_q[{cnt_q, 4'b0000} +: 16];
    b_slice   = b_q[{cnt_q, 4'b0000} +: 16];
    slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {16'd0, carry_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      acc_q   <= 64'd0;
      sum_q   <= 64'd0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            cnt_q <= 2'd0;
`ifdef ADD64_SUB_EN
            // Subtract as a + ~b + 1; cin is deliberately ignored here.
            b_q     <= op ? ~b : b;
            carry_q <= op ? 1'b1 : cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q[{cnt_q, 4'b0000} +: 16] <= slice_res[15:0];
          carry_q <= slice_res[16];
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            sum_q   <= {slice_res[15:0], acc_q[47:0]};
            cout_q  <= slice_res[16];
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
